audio_clip_engine: RTL and testbench
====================================

# audio_clip_engine

Parametrised record/playback engine that replaces the fixed single-buffer record/play path of the audio recorder top level. It sits between the microphone sample source, an external word-addressed memory port, and the PWM output latch. It partitions memory into 2**SLOT_SEL_BITS clip slots and tracks the recorded length of each slot, so playback ends at the recorded end rather than the memory end. It adds loop playback, a slot-full stop, and overrun detection.

## Interface
- SAMPLE_BITS, 12, width of one audio sample / memory word used
- ADDR_BITS, 23, memory word-address width
- SLOT_SEL_BITS, 2, slot select width; SLOTS = 2**SLOT_SEL_BITS; slot capacity CAP = 2**(ADDR_BITS-SLOT_SEL_BITS) words
- Clock  in  1  single clock for all logic
- Reset  in  1  synchronous, active-high
- Record, Play, Stop  in  1 each  single-cycle command pulses, already synchronised upstream
- Loop  in  1  level; sampled on an accepted Play
- Slot  in  SLOT_SEL_BITS  target slot; sampled on an accepted Record/Play
- SampleTick  in  1  one-cycle sample-rate strobe: captures SampleIn when recording, paces reads when playing
- SampleIn  in  SAMPLE_BITS  sample valid on SampleTick
- MemReq  out  1  memory request
- MemWrite  out  1  1 = write, 0 = read; valid with MemReq
- MemAddr  out  ADDR_BITS  {slot, offset}
- MemWData  out  SAMPLE_BITS  write data
- MemAck  in  1  request complete; read data valid this cycle
- MemRData  in  SAMPLE_BITS  read data
- SampleOut  out  SAMPLE_BITS  last played sample, held between updates
- SampleOutValid  out  1  one-cycle strobe on SampleOut update
- Recording, Playing, Idle  out  1 each  one-hot status
- Full  out  1  one-cycle pulse when a recording stops at CAP
- Overrun  out  1  sticky: a SampleTick was dropped
- SlotValid  out  SLOTS  bit n = slot n holds a non-zero-length clip

## Operation
- Per-slot length register len[n], ADDR_BITS-SLOT_SEL_BITS+1 bits wide, range 0..CAP. Offset counter has the same width.
- IDLE:
  - Record: latch Slot, clear len[slot] and offset, clear Overrun, go REC_WAIT.
  - Play: if len[slot]=0, no-op and stay IDLE. Otherwise latch Slot and Loop, offset=0, clear Overrun, go PLAY_WAIT.
  - Record and Play in the same cycle: Record wins.
  - Stop: no effect.
- REC_WAIT:
  - Stop: go IDLE. Stop wins over a same-cycle SampleTick.
  - SampleTick: register SampleIn into MemWData, issue a write to {slot,offset}, go REC_WR.
- REC_WR:
  - On MemAck: len[slot]=offset+1, offset++.
  - If offset+1=CAP: pulse Full and go IDLE. Else if a Stop is pending: go IDLE. Else: go REC_WAIT.
- PLAY_WAIT:
  - Stop: go IDLE.
  - SampleTick: issue a read of {slot,offset}, go PLAY_RD.
- PLAY_RD:
  - On MemAck: SampleOut<=MemRData.
  - If a Stop is pending: go IDLE.
  - Else if offset+1=len[slot]: with Loop latched, offset=0 and go PLAY_WAIT; otherwise go IDLE.
  - Else: offset++ and go PLAY_WAIT.
- Stop during REC_WR/PLAY_RD is latched as pending. The outstanding transaction always completes; it is never abandoned.
- SampleTick during REC_WR/PLAY_RD sets Overrun. The sample or read is dropped, with no extra memory request.
- Record/Play while not IDLE are ignored.
- SlotValid[n] = (len[n] != 0). Re-recording a slot clears its bit until the first write is acked.

## Timing
- Reset values: MemReq=0, MemWrite=0, MemAddr=0, MemWData=0, SampleOut=0, SampleOutValid=0, Recording=0, Playing=0, Idle=1, Full=0, Overrun=0, SlotValid=0. All len=0, state IDLE.
- All outputs are registered.
- MemReq rises the cycle after an accepted SampleTick.
- MemReq, MemWrite, MemAddr and MemWData are held stable until and including the MemAck cycle. MemReq drops the following cycle.
- MemAck is honoured only while MemReq=1, including in its first high cycle. MemAck while MemReq=0 is ignored.
- SampleOutValid and Full are high for exactly the one cycle after the MemAck cycle.
- Status outputs change the cycle after the state transition.
- Minimum SampleTick spacing without overrun is memory ack latency + 2 cycles.
- Reset mid-transaction drops MemReq the next cycle and discards all lengths.

## Test plan
- Reset held 2 cycles → every output equals its reset value, Idle=1, SlotValid=0.
- Record slot 1, ticks with 0x123/0x456/0x789, 1-cycle ack, then Stop → writes to offsets 0..2 of slot 1, Idle=1, SlotValid=0010.
- Play slot 1, Loop=0, 4 ticks → SampleOut 0x123, 0x456, 0x789 with three SampleOutValid pulses, then Idle; the 4th tick issues no MemReq. Repeat with Loop=1 → 4th output is 0x123.
- Build with ADDR_BITS=6, SLOT_SEL_BITS=2 (CAP=16); record slot 3 with 17 ticks → 16 writes at addresses 0x30..0x3F, Full pulse after the 16th ack, Idle; the 17th tick is ignored.
- Ack delayed 5 cycles, SampleTick during REC_WR → Overrun=1, exactly one write per accepted tick; Overrun cleared by the next accepted Record.
- Stop asserted while a write awaits ack → MemReq held until ack, len includes that sample, then Idle. Play on an empty slot → no MemReq, stays Idle. Record+Play same cycle → Recording=1.

Source files
------------

// File: rtl/audio_clip_engine.sv
// audio_clip_engine: slot-partitioned clip record/playback engine driving a word-addressed memory port
module audio_clip_engine #(
  parameter int SAMPLE_BITS = 12,
  parameter int ADDR_BITS = 23,
  parameter int SLOT_SEL_BITS = 2
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Record,
  input  logic Play,
  input  logic Stop,
  input  logic Loop,
  input  logic [SLOT_SEL_BITS-1:0] Slot,
  input  logic SampleTick,
  input  logic [SAMPLE_BITS-1:0] SampleIn,
  output logic MemReq,
  output logic MemWrite,
  output logic [ADDR_BITS-1:0] MemAddr,
  output logic [SAMPLE_BITS-1:0] MemWData,
  input  logic MemAck,
  input  logic [SAMPLE_BITS-1:0] MemRData,
  output logic [SAMPLE_BITS-1:0] SampleOut,
  output logic SampleOutValid,
  output logic Recording,
  output logic Playing,
  output logic Idle,
  output logic Full,
  output logic Overrun,
  output logic [2**SLOT_SEL_BITS-1:0] SlotValid
);
  localparam int OFF_BITS = ADDR_BITS - SLOT_SEL_BITS;
  localparam int LEN_BITS = OFF_BITS + 1;
  localparam int SLOTS = 2**SLOT_SEL_BITS;
  localparam logic [LEN_BITS-1:0] CAP = {1'b1, {OFF_BITS{1'b0}}};
  localparam logic [2:0] IDLE = 3'd0, REC_WAIT = 3'd1, REC_WR = 3'd2, PLAY_WAIT = 3'd3, PLAY_RD = 3'd4;
  logic [2:0] state, nextState;
  logic [SLOT_SEL_BITS-1:0] slotReg;
  logic loopReg, stopPending, ack, stopNow, busy;
  logic [LEN_BITS-1:0] offset, offsetInc;
  logic [LEN_BITS-1:0] len [SLOTS];
  assign ack = MemAck & MemReq;
  assign stopNow = Stop | stopPending;
  assign busy = state == REC_WR || state == PLAY_RD;
  assign offsetInc = offset + LEN_BITS'(1);
  always_comb begin
    nextState = IDLE;
    case (state)
      IDLE:      nextState = Record ? REC_WAIT : (Play && len[Slot] != '0) ? PLAY_WAIT : IDLE;
      REC_WAIT:  nextState = Stop ? IDLE : SampleTick ? REC_WR : REC_WAIT;
      REC_WR:    nextState = !ack ? REC_WR : (offsetInc == CAP || stopNow) ? IDLE : REC_WAIT;
      PLAY_WAIT: nextState = Stop ? IDLE : SampleTick ? PLAY_RD : PLAY_WAIT;
      PLAY_RD:   nextState = !ack ? PLAY_RD : (stopNow || (offsetInc == len[slotReg] && !loopReg)) ? IDLE : PLAY_WAIT;
      default:   nextState = IDLE;
    endcase
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      slotReg <= '0;
      loopReg <= 1'b0;
      stopPending <= 1'b0;
      offset <= '0;
      for (int i = 0; i < SLOTS; i++) len[i] <= '0;
      MemReq <= 1'b0;
      MemWrite <= 1'b0;
      MemAddr <= '0;
      MemWData <= '0;
      SampleOut <= '0;
      SampleOutValid <= 1'b0;
      Recording <= 1'b0;
      Playing <= 1'b0;
      Idle <= 1'b1;
      Full <= 1'b0;
      Overrun <= 1'b0;
      SlotValid <= '0;
    end else begin
      state <= nextState;
      Recording <= nextState == REC_WAIT || nextState == REC_WR;
      Playing <= nextState == PLAY_WAIT || nextState == PLAY_RD;
      Idle <= nextState == IDLE;
      SampleOutValid <= 1'b0;
      Full <= 1'b0;
      stopPending <= busy && !ack && stopNow;
      if (ack) MemReq <= 1'b0;
      if (busy && SampleTick) Overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (nextState != IDLE) begin
            slotReg <= Slot;
            loopReg <= Loop;
            offset <= '0;
            Overrun <= 1'b0;
          end
          if (Record) begin
            len[Slot] <= '0;
            SlotValid[Slot] <= 1'b0;
          end
        end
        REC_WAIT, PLAY_WAIT: begin
          if (!Stop && SampleTick) begin
            MemReq <= 1'b1;
            MemWrite <= state == REC_WAIT;
            MemAddr <= {slotReg, offset[OFF_BITS-1:0]};
            if (state == REC_WAIT) MemWData <= SampleIn;
          end
        end
        REC_WR: begin
          if (ack) begin
            len[slotReg] <= offsetInc;
            SlotValid[slotReg] <= 1'b1;
            offset <= offsetInc;
            Full <= offsetInc == CAP;
          end
        end
        PLAY_RD: begin
          if (ack) begin
            SampleOut <= MemRData;
            SampleOutValid <= 1'b1;
            offset <= offsetInc == len[slotReg] ? '0 : offsetInc;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_audio_clip_engine.sv
// tb_audio_clip_engine: directed record/playback scenarios checked against a transaction-level clip model
module tb_audio_clip_engine;
  localparam int CAP = 16;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  logic Record = 0, Play = 0, Stop = 0, Loop = 0, SampleTick = 0;
  logic [1:0] Slot = '0;
  logic [11:0] SampleIn = '0;
  logic MemReq, MemWrite, MemAck = 0;
  logic [5:0] MemAddr;
  logic [11:0] MemWData, MemRData = '0, SampleOut;
  logic SampleOutValid, Recording, Playing, Idle, Full, Overrun;
  logic [3:0] SlotValid;
  logic rstQ = 1'b1;
  int checks = 0, errors = 0;
  int ackDelay = 0, waitCnt = 0, fullSeen = 0, wrSeen = 0, rdSeen = 0, lastWrAddr = 0;
  bit stray = 0;
  logic [11:0] mem [64];
  int modelLen [4];
  int modelMem [64];
  int expWrAddr[$], expWrData[$], expRdAddr[$], expSample[$];

  audio_clip_engine #(.SAMPLE_BITS(12), .ADDR_BITS(6), .SLOT_SEL_BITS(2)) dut (
    .Clock(Clock), .Reset(Reset), .Record(Record), .Play(Play), .Stop(Stop), .Loop(Loop),
    .Slot(Slot), .SampleTick(SampleTick), .SampleIn(SampleIn), .MemReq(MemReq),
    .MemWrite(MemWrite), .MemAddr(MemAddr), .MemWData(MemWData), .MemAck(MemAck),
    .MemRData(MemRData), .SampleOut(SampleOut), .SampleOutValid(SampleOutValid),
    .Recording(Recording), .Playing(Playing), .Idle(Idle), .Full(Full),
    .Overrun(Overrun), .SlotValid(SlotValid));

  always #5 Clock = ~Clock;
  always @(posedge Clock) rstQ <= Reset;

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // memory responder: ack after ackDelay extra cycles, plus an optional stray ack while idle
  initial forever begin
    @(posedge Clock);
    #2;
    MemAck = 0;
    if (Reset || !MemReq) begin
      waitCnt = 0;
      if (stray && !MemReq) begin MemAck = 1; stray = 0; end
    end else if (waitCnt == ackDelay) begin
      MemAck = 1;
      MemRData = mem[MemAddr];
      if (MemWrite) mem[MemAddr] = MemWData;
      waitCnt = 0;
    end else waitCnt++;
  end

  // compare process
  initial begin
    bit prevReq, prevAck, prevWe, expValid, expFull;
    int prevAddr, prevWData;
    prevReq = 0; prevAck = 0; prevWe = 0; expValid = 0; expFull = 0; prevAddr = 0; prevWData = 0;
    forever begin
      @(negedge Clock);
      if (rstQ) begin
        prevReq = 0; expValid = 0; expFull = 0;
      end else begin
        chk("status_onehot", $countones({Recording, Playing, Idle}), 1);
        chk("sample_valid", int'(SampleOutValid), int'(expValid));
        chk("full_pulse", int'(Full), int'(expFull));
        if (Full) fullSeen++;
        if (SampleOutValid && expValid) begin
          chk("sample_expected", int'(expSample.size() > 0), 1);
          if (expSample.size() > 0) chk("sample_out", int'(SampleOut), expSample.pop_front());
        end
        if (prevReq && !prevAck) begin
          chk("req_held", int'(MemReq), 1);
          chk("addr_held", int'(MemAddr), prevAddr);
          chk("we_held", int'(MemWrite), int'(prevWe));
          if (prevWe) chk("wdata_held", int'(MemWData), prevWData);
        end
        expValid = 0;
        expFull = 0;
        if (MemReq && MemAck) begin
          if (MemWrite) begin
            wrSeen++;
            lastWrAddr = int'(MemAddr);
            chk("wr_expected", int'(expWrAddr.size() > 0), 1);
            if (expWrAddr.size() > 0) begin
              chk("wr_addr", int'(MemAddr), expWrAddr.pop_front());
              chk("wr_data", int'(MemWData), expWrData.pop_front());
            end
            expFull = (int'(MemAddr) % CAP) == CAP - 1;
          end else begin
            rdSeen++;
            chk("rd_expected", int'(expRdAddr.size() > 0), 1);
            if (expRdAddr.size() > 0) chk("rd_addr", int'(MemAddr), expRdAddr.pop_front());
            expValid = 1;
          end
        end
        prevReq = MemReq; prevAck = MemAck; prevWe = MemWrite;
        prevAddr = int'(MemAddr); prevWData = int'(MemWData);
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic tick(int d, int gap);
    SampleIn = 12'(d);
    SampleTick = 1;
    cyc(1);
    SampleTick = 0;
    cyc(gap);
  endtask

  task automatic stopCmd();
    Stop = 1;
    cyc(1);
    Stop = 0;
    cyc(2);
  endtask

  task automatic recPulse(int s);
    Record = 1;
    Slot = 2'(s);
    cyc(1);
    Record = 0;
    modelLen[s] = 0;
  endtask

  // a recording keeps the first CAP samples of the session; the rest find the engine idle
  task automatic rec(int s, int n, int seed, int step);
    int d;
    recPulse(s);
    for (int i = 0; i < n; i++) begin
      d = (seed + i * step) & 'hFFF;
      if (i < CAP) begin
        expWrAddr.push_back(s * CAP + i);
        expWrData.push_back(d);
        modelMem[s * CAP + i] = d;
        modelLen[s] = i + 1;
      end
      tick(d, ackDelay + 3);
    end
  endtask

  // playback walks 0..len-1, wrapping when looping, and ends at len otherwise
  task automatic play(int s, bit lp, int n);
    int a;
    Play = 1;
    Slot = 2'(s);
    Loop = lp;
    cyc(1);
    Play = 0;
    for (int i = 0; i < n; i++) begin
      if (modelLen[s] != 0 && (lp || i < modelLen[s])) begin
        a = s * CAP + (i % modelLen[s]);
        expRdAddr.push_back(a);
        expSample.push_back(modelMem[a]);
      end
      tick(0, ackDelay + 3);
    end
  endtask

  initial begin
    int r0;
    for (int i = 0; i < 4; i++) modelLen[i] = 0;
    for (int i = 0; i < 64; i++) begin modelMem[i] = 0; mem[i] = '0; end
    cyc(2);
    chk("rst_memreq", int'(MemReq), 0);
    chk("rst_memwrite", int'(MemWrite), 0);
    chk("rst_memaddr", int'(MemAddr), 0);
    chk("rst_memwdata", int'(MemWData), 0);
    chk("rst_sampleout", int'(SampleOut), 0);
    chk("rst_valid", int'(SampleOutValid), 0);
    chk("rst_status", int'({Recording, Playing, Idle}), 1);
    chk("rst_full", int'(Full), 0);
    chk("rst_overrun", int'(Overrun), 0);
    chk("rst_slotvalid", int'(SlotValid), 0);
    Reset = 0;
    cyc(2);
    stray = 1;
    cyc(4);
    chk("stray_ack_idle", int'(Idle), 1);
    play(0, 0, 2);
    chk("play_empty_idle", int'(Idle), 1);
    chk("play_empty_reads", rdSeen, 0);
    rec(1, 3, 'h123, 'h333);
    chk("rec1_recording", int'(Recording), 1);
    stopCmd();
    chk("rec1_idle", int'(Idle), 1);
    chk("rec1_slotvalid", int'(SlotValid), 'b0010);
    chk("rec1_writes", wrSeen, 3);
    r0 = rdSeen;
    play(1, 0, 4);
    chk("play_nl_idle", int'(Idle), 1);
    chk("play_nl_reads", rdSeen - r0, 3);
    chk("play_nl_last", int'(SampleOut), 'h789);
    play(1, 1, 4);
    chk("play_loop_playing", int'(Playing), 1);
    chk("play_loop_4th", int'(SampleOut), 'h123);
    stopCmd();
    chk("play_loop_stop_idle", int'(Idle), 1);
    rec(3, 17, 'h100, 'h011);
    chk("full_idle", int'(Idle), 1);
    chk("full_pulses", fullSeen, 1);
    chk("full_last_addr", lastWrAddr, 'h3F);
    chk("full_writes", wrSeen, 19);
    chk("full_slotvalid", int'(SlotValid), 'b1010);
    ackDelay = 5;
    recPulse(0);
    expWrAddr.push_back(0); expWrData.push_back('hA01); modelMem[0] = 'hA01;
    tick('hA01, 1);
    tick('hBAD, 12);
    chk("overrun_set", int'(Overrun), 1);
    expWrAddr.push_back(1); expWrData.push_back('hA02); modelMem[1] = 'hA02;
    tick('hA02, 10);
    modelLen[0] = 2;
    stopCmd();
    chk("overrun_writes", wrSeen, 21);
    chk("overrun_sticky", int'(Overrun), 1);
    chk("overrun_slotvalid", int'(SlotValid), 'b1011);
    ackDelay = 4;
    recPulse(2);
    chk("overrun_cleared", int'(Overrun), 0);
    expWrAddr.push_back(2 * CAP); expWrData.push_back('h5C5); modelMem[2 * CAP] = 'h5C5;
    tick('h5C5, 1);
    Stop = 1;
    cyc(1);
    Stop = 0;
    chk("stop_pending_req", int'(MemReq), 1);
    cyc(10);
    modelLen[2] = 1;
    chk("stop_pending_idle", int'(Idle), 1);
    chk("stop_pending_slotvalid", int'(SlotValid), 'b1111);
    play(2, 0, 2);
    chk("stop_pending_sample", int'(SampleOut), 'h5C5);
    play(0, 0, 3);
    chk("play0_last", int'(SampleOut), 'hA02);
    Record = 1; Play = 1; Slot = 2'd0;
    cyc(1);
    Record = 0; Play = 0;
    modelLen[0] = 0;
    chk("rec_play_recording", int'(Recording), 1);
    chk("rec_play_playing", int'(Playing), 0);
    stopCmd();
    chk("rec_play_slotvalid", int'(SlotValid), 'b1110);
    ackDelay = 5;
    recPulse(1);
    SampleIn = 12'h777;
    SampleTick = 1;
    cyc(1);
    SampleTick = 0;
    chk("midrst_req", int'(MemReq), 1);
    Reset = 1;
    cyc(1);
    chk("midrst_req_drop", int'(MemReq), 0);
    chk("midrst_slotvalid", int'(SlotValid), 0);
    chk("midrst_idle", int'(Idle), 1);
    Reset = 0;
    for (int i = 0; i < 4; i++) modelLen[i] = 0;
    cyc(6);
    chk("end_wr_left", expWrAddr.size(), 0);
    chk("end_rd_left", expRdAddr.size(), 0);
    chk("end_sample_left", expSample.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
